tm1638_driver: RTL and testbench

- Serial bus engine between the segment/button sequencer and a TM1638 LED&KEY board.
- Accepts single-digit write requests (index plus hex nibble) and button-read requests through a READY/request handshake.
- Encodes each nibble to 7-segment form and bit-bangs the TM1638 STB/CLK/DIO protocol.
- Returns an 8-bit button vector to the core.

---
 rtl/tm1638_driver.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_tm1638_driver.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_driver.sv
// tm1638_driver: serial bus engine between the segment/button sequencer and a
// TM1638 LED&KEY board. It takes single-digit writes and button reads over a
// READY/request handshake and bit-bangs the STB/CLK/DIO protocol, LSB first.
//
// Optional feature: define TM1638_LED_EN to add LEDS[7:0]. Each digit write is
// then followed by a second frame that sets the LED at the same index.
//
// Ports:
//   CLK_IN, RST_IN           clock; synchronous active-high reset
//   READY                    high only in IDLE, when requests are sampled
//   WRITE_SEG, READ_BUTTON   request strobes (a read wins if both are high)
//   SEG_INDEX, SEG_DATA      digit position and hex nibble, captured when IDLE is left
//   LEDS                     LED states (TM1638_LED_EN builds only)
//   BUTTONS, BUTTONS_VALID   key snapshot (bit i = key S(i+1)) and its one-cycle update pulse
//   TM_STB, TM_CLK           strobe (frame is active low) and serial clock (idles high)
//   TM_DIO_OUT, TM_DIO_OE    DIO drive value and enable; the tristate buffer is at top level
//   TM_DIO_IN                sampled DIO value
module tm1638_driver #(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [2:0]  BRIGHTNESS = 3'd7,
    parameter int unsigned READ_WAIT  = 8
) (
    input  logic       CLK_IN,
    input  logic       RST_IN,
    output logic       READY,
    input  logic       WRITE_SEG,
    input  logic       READ_BUTTON,
    input  logic [2:0] SEG_INDEX,
    input  logic [3:0] SEG_DATA,
`ifdef TM1638_LED_EN
    input  logic [7:0] LEDS,
`endif
    output logic [7:0] BUTTONS,
    output logic       BUTTONS_VALID,
    output logic       TM_STB,
    output logic       TM_CLK,
    output logic       TM_DIO_OUT,
    output logic       TM_DIO_OE,
    input  logic       TM_DIO_IN
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_W_CMD, S_W_DATA, S_R_CMD, S_R_WAIT, S_R_DATA, S_GAP
    } state_t;

    // Sub-phase of a frame state. PH_OFF is the single cycle before STB falls.
    // In PH_BIT, clk_q tells the low half from the high half of the bit.
    typedef enum logic [1:0] {PH_OFF, PH_START, PH_BIT, PH_TAIL} phase_t;

    state_t           state_q, state_d, ret_q, ret_d;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [7:0]       acc_q, acc_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       nib_q, nib_d;
    logic             stb_q, stb_d, clk_q, clk_d, dio_q, dio_d, oe_q, oe_d;
    logic             ready_q, ready_d, valid_q, valid_d;
    logic [7:0]       buttons_q, buttons_d;
    logic [7:0]       cur_tx, nxt_tx;
    logic             cnt_hit, reading, last_byte;

`ifdef TM1638_LED_EN
    logic led_q, led_d, ledph_q, ledph_d;

    // LED value and "second frame in progress" flag for the LED write.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            led_q   <= 1'b0;
            ledph_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            ledph_q <= ledph_d;
        end
    end
`else
    logic led_q, ledph_q;
    assign led_q   = 1'b0;
    assign ledph_q = 1'b0;
`endif

    // Hex nibble to {dp=0, gfedcba}.
    function automatic logic [7:0] seg_f(input logic [3:0] n);
        case (n)
            4'h0: seg_f = 8'h3F;  4'h1: seg_f = 8'h06;  4'h2: seg_f = 8'h5B;  4'h3: seg_f = 8'h4F;
            4'h4: seg_f = 8'h66;  4'h5: seg_f = 8'h6D;  4'h6: seg_f = 8'h7D;  4'h7: seg_f = 8'h07;
            4'h8: seg_f = 8'h7F;  4'h9: seg_f = 8'h6F;  4'hA: seg_f = 8'h77;  4'hB: seg_f = 8'h7C;
            4'hC: seg_f = 8'h39;  4'hD: seg_f = 8'h5E;  4'hE: seg_f = 8'h79;  default: seg_f = 8'h71;
        endcase
    endfunction

    // Byte to transmit. sel picks byte 1 of the two-byte data frame.
    // The LED frame uses the odd address next to the digit.
    function automatic logic [7:0] tx_f(input state_t s, input logic sel, input logic ledph,
                                        input logic [2:0] idx, input logic [3:0] nib,
                                        input logic led);
        logic [7:0] addr;
        addr = 8'hC0 + {4'd0, idx, ledph};
        case (s)
            S_INIT:   tx_f = 8'h88 | {5'd0, BRIGHTNESS};
            S_W_CMD:  tx_f = 8'h44;
            S_R_CMD:  tx_f = 8'h42;
            S_W_DATA: tx_f = !sel ? addr : (ledph ? {7'd0, led} : seg_f(nib));
            default:  tx_f = 8'hFF;
        endcase
    endfunction

    // State and output registers.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state_q   <= S_INIT;
            ret_q     <= S_IDLE;
            phase_q   <= PH_OFF;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            nib_q     <= '0;
            stb_q     <= 1'b1;
            clk_q     <= 1'b1;
            dio_q     <= 1'b1;
            oe_q      <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            buttons_q <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            nib_q     <= nib_d;
            stb_q     <= stb_d;
            clk_q     <= clk_d;
            dio_q     <= dio_d;
            oe_q      <= oe_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            buttons_q <= buttons_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        byte_d    = byte_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        nib_d     = nib_q;
        stb_d     = stb_q;
        clk_d     = clk_q;
        dio_d     = dio_q;
        valid_d   = 1'b0;
        buttons_d = buttons_q;
`ifdef TM1638_LED_EN
        led_d     = led_q;
        ledph_d   = ledph_q;
`endif

        cnt_hit   = (cnt_q == DIV_LAST);
        reading   = (state_q == S_R_DATA);
        last_byte = reading ? (byte_q == 2'd3)
                  : (state_q == S_W_DATA) ? (byte_q == 2'd1) : (byte_q == 2'd0);
        cur_tx    = tx_f(state_q, byte_q[0], ledph_q, idx_q, nib_q, led_q);
        nxt_tx    = tx_f(state_q, 1'b1, ledph_q, idx_q, nib_q, led_q);

        case (state_q)
            S_IDLE: begin
                if (READ_BUTTON) begin
                    state_d = S_R_CMD;
                    phase_d = PH_OFF;
                end else if (WRITE_SEG) begin
                    state_d = S_W_CMD;
                    phase_d = PH_OFF;
                    idx_d   = SEG_INDEX;
                    nib_d   = SEG_DATA;
`ifdef TM1638_LED_EN
                    led_d   = LEDS[SEG_INDEX];
                    ledph_d = 1'b0;
`endif
                end
            end
            S_R_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_R_DATA;
                    phase_d = PH_BIT;
                    clk_d   = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ret_q;
                    phase_d = PH_OFF;
                    cnt_d   = '0;
                end
            end
            default: begin
                case (phase_q)
                    PH_OFF: begin
                        stb_d   = 1'b0;
                        phase_d = PH_START;
                        cnt_d   = '0;
                        bit_d   = '0;
                        byte_d  = '0;
                    end
                    PH_START: begin
                        if (cnt_hit) begin
                            phase_d = PH_BIT;
                            clk_d   = 1'b0;
                            cnt_d   = '0;
                            dio_d   = cur_tx[0];
                        end
                    end
                    PH_BIT: begin
                        if (cnt_hit) begin
                            cnt_d = '0;
                            if (!clk_q) begin
                                clk_d = 1'b1;
                            end else begin
                                // Only bits 0 and 4 of each read byte carry keys.
                                if (reading && bit_q == 3'd0) acc_d[{1'b0, byte_q}] = TM_DIO_IN;
                                if (reading && bit_q == 3'd4) acc_d[{1'b1, byte_q}] = TM_DIO_IN;
                                if (bit_q != 3'd7) begin
                                    bit_d = bit_q + 3'd1;
                                    clk_d = 1'b0;
                                    if (!reading) dio_d = cur_tx[bit_q + 3'd1];
                                end else if (!last_byte) begin
                                    bit_d  = '0;
                                    byte_d = byte_q + 2'd1;
                                    clk_d  = 1'b0;
                                    if (!reading) dio_d = nxt_tx[0];
                                end else if (state_q == S_R_CMD) begin
                                    // STB stays low into the read wait.
                                    state_d = S_R_WAIT;
                                end else begin
                                    phase_d = PH_TAIL;
                                end
                            end
                        end
                    end
                    default: begin
                        if (cnt_hit) begin
                            stb_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = S_GAP;
                            phase_d = PH_OFF;
                            case (state_q)
                                S_W_CMD:  ret_d = S_W_DATA;
                                S_W_DATA: begin
`ifdef TM1638_LED_EN
                                    if (!ledph_q) begin
                                        ret_d   = S_W_DATA;
                                        ledph_d = 1'b1;
                                    end else begin
                                        ret_d = S_IDLE;
                                    end
`else
                                    ret_d = S_IDLE;
`endif
                                end
                                default:  ret_d = S_IDLE;
                            endcase
                            if (reading) begin
                                buttons_d = acc_q;
                                valid_d   = 1'b1;
                            end
                        end
                    end
                endcase
            end
        endcase

        oe_d    = !stb_d && (state_d == S_INIT || state_d == S_W_CMD ||
                             state_d == S_W_DATA || state_d == S_R_CMD);
        ready_d = (state_d == S_IDLE);
    end

    assign READY         = ready_q;
    assign BUTTONS       = buttons_q;
    assign BUTTONS_VALID = valid_q;
    assign TM_STB        = stb_q;
    assign TM_CLK        = clk_q;
    assign TM_DIO_OUT    = dio_q;
    assign TM_DIO_OE     = oe_q;

endmodule

// File: tb/tb_tm1638_driver.sv
// Testbench for tm1638_driver: a board model decodes bus frames. The expected
// frames and button values are built from the protocol rules.
module tb_tm1638_driver;
    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned READ_WAIT = 5;

    logic       CLK_IN = 1'b0;
    logic       RST_IN = 1'b1;
    logic       READY;
    logic       WRITE_SEG = 1'b0;
    logic       READ_BUTTON = 1'b0;
    logic [2:0] SEG_INDEX = 3'd0;
    logic [3:0] SEG_DATA = 4'd0;
    logic [7:0] LEDS = 8'd0;
    logic [7:0] BUTTONS;
    logic       BUTTONS_VALID;
    logic       TM_STB, TM_CLK, TM_DIO_OUT, TM_DIO_OE;
    logic       TM_DIO_IN = 1'b1;

    tm1638_driver #(.CLK_DIV(CLK_DIV), .BRIGHTNESS(3'd7), .READ_WAIT(READ_WAIT)) dut (
        .CLK_IN(CLK_IN), .RST_IN(RST_IN), .READY(READY),
        .WRITE_SEG(WRITE_SEG), .READ_BUTTON(READ_BUTTON),
        .SEG_INDEX(SEG_INDEX), .SEG_DATA(SEG_DATA),
`ifdef TM1638_LED_EN
        .LEDS(LEDS),
`endif
        .BUTTONS(BUTTONS), .BUTTONS_VALID(BUTTONS_VALID),
        .TM_STB(TM_STB), .TM_CLK(TM_CLK), .TM_DIO_OUT(TM_DIO_OUT),
        .TM_DIO_OE(TM_DIO_OE), .TM_DIO_IN(TM_DIO_IN)
    );

    always #5 CLK_IN = ~CLK_IN;

    typedef struct packed { logic [7:0] n; logic [39:0] b; } frame_t;
    frame_t cap_q[$];
    frame_t exp_q[$];

    int total = 0;
    int bad   = 0;
    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Board model state.
    logic        p_stb = 1'b1, p_clk = 1'b1, p_dio = 1'b1;
    logic        in_frame = 1'b0, rd_mode = 1'b0;
    int          nbits = 0, cd = 0, hi_cnt = 1000;
    int          stab_err = 0, oe_err = 0, gap_err = 0, valid_cycles = 0;
    logic [39:0] fb = '0;
    logic [31:0] rd_data = '0;
    logic [7:0]  btn_at_valid = '0;

    always @(negedge CLK_IN) begin
        if (BUTTONS_VALID) begin
            valid_cycles++;
            btn_at_valid = BUTTONS;
        end
        if (RST_IN) begin
            in_frame  = 1'b0;
            rd_mode   = 1'b0;
            TM_DIO_IN = 1'b1;
            hi_cnt    = 1000;
        end else begin
            if (in_frame && rd_mode) begin
                if (cd > 0) cd--;
                else if (TM_DIO_OE) oe_err++;
            end
            if (in_frame && TM_CLK && p_clk && TM_DIO_OUT !== p_dio) stab_err++;
            if (p_stb && !TM_STB) begin
                if (hi_cnt < int'(2 * CLK_DIV)) gap_err++;
                in_frame = 1'b1;
                nbits    = 0;
                fb       = '0;
                rd_mode  = 1'b0;
            end
            if (TM_STB) hi_cnt++;
            if (in_frame && !TM_STB && !p_clk && TM_CLK) begin
                if (nbits < 40) fb[nbits] = TM_DIO_OE ? TM_DIO_OUT : TM_DIO_IN;
                nbits++;
                if (nbits == 8 && fb[7:0] == 8'h42) begin
                    rd_mode = 1'b1;
                    cd      = int'(CLK_DIV) - 1;
                end
            end
            if (in_frame && rd_mode && p_clk && !TM_CLK && nbits >= 8 && nbits < 40)
                TM_DIO_IN = rd_data[nbits-8];
            if (in_frame && !p_stb && TM_STB) begin
                cap_q.push_back({8'(nbits / 8), fb});
                in_frame  = 1'b0;
                rd_mode   = 1'b0;
                TM_DIO_IN = 1'b1;
                hi_cnt    = 1;
            end
        end
        p_stb = TM_STB;
        p_clk = TM_CLK;
        p_dio = TM_DIO_OUT;
    end

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!READY && n < 4000) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 64'(READY), 64'd1);
    endtask

    function automatic void exp_frame(input int n, input logic [39:0] b);
        exp_q.push_back({8'(n), b});
    endfunction

    task automatic drain(input string tag);
        frame_t c, e;
        repeat (4) tick();
        check({tag, "_nframes"}, 64'(cap_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            c = cap_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_frame"}, 64'(c), 64'(e));
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    function automatic void exp_write(input logic [2:0] idx, input logic [3:0] nib,
                                      input logic [7:0] leds);
        exp_frame(1, 40'h44);
        exp_frame(2, {24'd0, seg_tab[nib], 8'hC0 + 8'(2 * idx)});
`ifdef TM1638_LED_EN
        exp_frame(2, {24'd0, 7'd0, leds[idx], 8'hC1 + 8'(2 * idx)});
`else
        if (leds === 8'hxx) exp_frame(0, '0);
`endif
    endfunction

    function automatic logic [7:0] exp_buttons(input logic [31:0] rd);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = rd[8 * (i % 4) + (i < 4 ? 0 : 4)];
        return v;
    endfunction

    task automatic do_write(input logic [2:0] idx, input logic [3:0] nib,
                            input logic [7:0] leds, input string tag);
        wait_ready({tag, "_pre"});
        SEG_INDEX = idx;
        SEG_DATA  = nib;
        LEDS      = leds;
        WRITE_SEG = 1'b1;
        tick();
        check({tag, "_rdy_drop"}, 64'(READY), 64'd0);
        WRITE_SEG = 1'b0;
        SEG_INDEX = 3'($urandom);
        SEG_DATA  = 4'($urandom);
        LEDS      = 8'($urandom);
        exp_write(idx, nib, leds);
        wait_ready(tag);
        drain(tag);
    endtask

    task automatic do_read(input logic [31:0] rd, input string tag);
        int v0;
        wait_ready({tag, "_pre"});
        rd_data     = rd;
        v0          = valid_cycles;
        READ_BUTTON = 1'b1;
        tick();
        check({tag, "_rdy_drop"}, 64'(READY), 64'd0);
        READ_BUTTON = 1'b0;
        exp_frame(5, {rd, 8'h42});
        wait_ready(tag);
        check({tag, "_buttons"}, 64'(BUTTONS), 64'(exp_buttons(rd)));
        check({tag, "_btn_at_valid"}, 64'(btn_at_valid), 64'(exp_buttons(rd)));
        check({tag, "_valid_cycles"}, 64'(valid_cycles - v0), 64'd1);
        drain(tag);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int n;

        // Reset values.
        repeat (3) tick();
        check("rst_stb", 64'(TM_STB), 64'd1);
        check("rst_clk", 64'(TM_CLK), 64'd1);
        check("rst_dio", 64'(TM_DIO_OUT), 64'd1);
        check("rst_oe", 64'(TM_DIO_OE), 64'd0);
        check("rst_ready", 64'(READY), 64'd0);
        check("rst_buttons", 64'(BUTTONS), 64'd0);
        check("rst_valid", 64'(BUTTONS_VALID), 64'd0);
        RST_IN = 1'b0;
        exp_frame(1, 40'h8F);
        wait_ready("init");
        check("init_no_valid", 64'(valid_cycles), 64'd0);
        drain("init");

        // Directed digit write, full segment table, directed key read.
        do_write(3'd3, 4'hA, 8'h08, "w3a");
        for (int i = 0; i < 16; i++) do_write(3'd0, 4'(i), 8'($urandom), "segtab");
        do_read(32'h10_01_00_11, "rd_dir");

        // Both requests high: the read goes first, the write follows on READY re-entry.
        wait_ready("prio_pre");
        r           = $urandom;
        rd_data     = r;
        SEG_INDEX   = 3'd5;
        SEG_DATA    = 4'h6;
        LEDS        = 8'h20;
        READ_BUTTON = 1'b1;
        WRITE_SEG   = 1'b1;
        tick();
        READ_BUTTON = 1'b0;
        exp_frame(5, {r, 8'h42});
        wait_ready("prio_r");
        check("prio_buttons", 64'(BUTTONS), 64'(exp_buttons(r)));
        tick();
        check("prio_w_rdy_drop", 64'(READY), 64'd0);
        WRITE_SEG = 1'b0;
        exp_write(3'd5, 4'h6, 8'h20);
        wait_ready("prio_w");
        drain("prio");

        // Random mix of reads and writes.
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 2) == 0) do_read($urandom, "rnd_rd");
            else do_write(3'($urandom), 4'($urandom), 8'($urandom), "rnd_wr");
        end

        // Reset in the middle of the data frame.
        wait_ready("mid_pre");
        SEG_INDEX = 3'd2;
        SEG_DATA  = 4'h7;
        WRITE_SEG = 1'b1;
        tick();
        WRITE_SEG = 1'b0;
        n = 0;
        while (cap_q.size() == 0 && n < 2000) begin tick(); n++; end
        while (TM_STB && n < 4000) begin tick(); n++; end
        repeat (20) tick();
        check("mid_stb_low", 64'(TM_STB), 64'd0);
        RST_IN = 1'b1;
        tick();
        check("mid_rst_stb", 64'(TM_STB), 64'd1);
        check("mid_rst_clk", 64'(TM_CLK), 64'd1);
        check("mid_rst_ready", 64'(READY), 64'd0);
        check("mid_rst_oe", 64'(TM_DIO_OE), 64'd0);
        tick();
        RST_IN = 1'b0;
        cap_q.delete();
        exp_q.delete();
        exp_frame(1, 40'h8F);
        wait_ready("reinit");
        drain("reinit");
        do_write(3'd7, 4'hF, 8'h80, "post_rst");

        check("dio_stable_high", 64'(stab_err), 64'd0);
        check("oe_low_in_read", 64'(oe_err), 64'd0);
        check("stb_gap", 64'(gap_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
